mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Reset is reset_n, asynchronous, active-low; clock is clk; all state updates on posedge clk.
REQ-002 clk  in  1  system clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 valid_in  in  1  EX/MEM slot holds a real instruction.
REQ-005 alu_result_in  in  8  ALU result and memory address.
REQ-006 store_data_in  in  8  store data.
REQ-007 rd_in  in  3  destination register.
REQ-008 alu_flag_in  in  4  ALU flags.
REQ-009 memread_in, memwrite_in, memtoreg_in, regwrite_in  in  1 each  control bits.
REQ-010 io_in  in  8  asynchronous external input port.
REQ-011 alu_result_out, mem_data_out  out  8 each  to MEM/WB register.
REQ-012 rd_out  out  3  destination register to MEM/WB.
REQ-013 alu_flag_out  out  4  flags to MEM/WB.
REQ-014 memtoreg_out, regwrite_out  out  1 each  controls to MEM/WB.
REQ-015 stall_out  out  1  upstream pipeline hold request.
REQ-016 io_out  out  8  registered output port.

Function
REQ-017 Address map:
- 0x00-0xFD: internal 256x8 RAM, synchronous read and write.
- 0xFE: io_in after a 2-flop synchronizer, read-only; writes ignored.
- 0xFF: io_out register, read/write.
REQ-018 FSM states are IDLE and LOAD_WAIT.
REQ-019 IDLE, valid_in=1, memread_in=1, memwrite_in=0:
- capture address, rd, flags, memtoreg and regwrite;
- start the read;
- assert stall_out=1 combinationally in that cycle;
- drive regwrite_out=0 (bubble);
- go to LOAD_WAIT.
REQ-020 LOAD_WAIT (exactly one cycle):
- stall_out=0;
- mem_data_out = read data;
- alu_result_out, rd_out, alu_flag_out, memtoreg_out and regwrite_out come from the captured copies;
- return to IDLE.
REQ-021 Load-use latency: 2 cycles from issue to data valid at the outputs; the MEM/WB register samples the data at the end of LOAD_WAIT.
REQ-022 IDLE store (valid_in=1, memwrite_in=1):
- write store_data_in at the posedge ending the cycle (RAM or io_out by address);
- stall_out=0;
- no state change.
REQ-023 memread_in and memwrite_in both 1: treat as a store only; no read, no stall.
REQ-024 IDLE, non-memory or valid_in=0: alu_result_out, rd_out, alu_flag_out and memtoreg_out pass through combinationally; regwrite_out = regwrite_in AND valid_in.
REQ-025 mem_data_out is driven from the registered read-data register; it holds its last value outside LOAD_WAIT.
REQ-026 Inputs arriving during LOAD_WAIT are ignored; upstream holds them stable while stall_out=1.
REQ-027 Back-to-back loads:
- every load costs 2 cycles;
- stall_out pattern is 1,0,1,0.
REQ-028 Store immediately following a load (in the cycle after LOAD_WAIT) is accepted without stall.
REQ-029 Address arithmetic: full 8-bit; no wrap-around or alignment logic needed.

Reset
REQ-030 reset_n low forces:
- state IDLE, stall_out=0;
- read-data register 0x00, io_out 0x00;
- synchronizer flops 0x00;
- captured copies 0.
REQ-031 RAM contents are not reset.
REQ-032 Reset asserted during LOAD_WAIT:
- the load is aborted;
- regwrite_out is 0 while reset is low;
- IDLE on the first edge after release.

Verification
REQ-033 Store 0x5A to 0x10, then load 0x10 (rd=3, regwrite=1) -> stall_out=1 in the issue cycle, regwrite_out=0; next cycle mem_data_out=0x5A, rd_out=3, regwrite_out=1, stall_out=0.
REQ-034 Store 0xA5 to 0xFF -> io_out=0xA5 after that edge; load 0xFF -> mem_data_out=0xA5.
REQ-035 io_in=0x3C held 3 cycles, then load 0xFE -> mem_data_out=0x3C; store 0x11 to 0xFE -> io_out unchanged.
REQ-036 Two consecutive loads from 0x01=0x11 and 0x02=0x22:
- stall_out sequence 1,0,1,0;
- mem_data_out 0x11 then 0x22 in the LOAD_WAIT cycles.
REQ-037 memread_in=memwrite_in=1, addr 0x20, data 0x77 -> no stall; a later load of 0x20 returns 0x77.
REQ-038 Reset pulse during LOAD_WAIT -> all outputs at reset values, state IDLE; a following ALU op (valid_in=1, regwrite_in=1) passes through with regwrite_out=1.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and the external I/O port of the memory stage.
// The master modport is the driving side (EX stage / bench); mem_stage takes the slave modport.
interface mem_stage_if;
    logic       valid_in;
    logic [7:0] alu_result_in;
    logic [7:0] store_data_in;
    logic [2:0] rd_in;
    logic [3:0] alu_flag_in;
    logic       memread_in;
    logic       memwrite_in;
    logic       memtoreg_in;
    logic       regwrite_in;
    logic [7:0] io_in;

    logic [7:0] alu_result_out;
    logic [7:0] mem_data_out;
    logic [2:0] rd_out;
    logic [3:0] alu_flag_out;
    logic       memtoreg_out;
    logic       regwrite_out;
    logic       stall_out;
    logic [7:0] io_out;

    modport master (
        output valid_in, alu_result_in, store_data_in, rd_in, alu_flag_in,
               memread_in, memwrite_in, memtoreg_in, regwrite_in, io_in,
        input  alu_result_out, mem_data_out, rd_out, alu_flag_out,
               memtoreg_out, regwrite_out, stall_out, io_out
    );

    modport slave (
        input  valid_in, alu_result_in, store_data_in, rd_in, alu_flag_in,
               memread_in, memwrite_in, memtoreg_in, regwrite_in, io_in,
        output alu_result_out, mem_data_out, rd_out, alu_flag_out,
               memtoreg_out, regwrite_out, stall_out, io_out
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: 256x8 synchronous RAM with a synchronized input port at 0xFE and an
// output register at 0xFF. Loads take two cycles (issue + LOAD_WAIT) and stall upstream once.
module mem_stage (
    input logic       clk,
    input logic       reset_n,
    mem_stage_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [2:0] rd_q, rd_d;
    logic [3:0] flag_q, flag_d;
    logic       memtoreg_q, memtoreg_d;
    logic       regwrite_q, regwrite_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] io_out_q, io_out_d;
    logic [7:0] sync1_q, sync2_q;
    logic [7:0] ram [256];
    logic       is_load, is_store, ram_we;

    // A request with both memread and memwrite set is handled as a plain store.
    assign is_load  = (state_q == StIdle) && bus.valid_in && bus.memread_in && !bus.memwrite_in;
    assign is_store = (state_q == StIdle) && bus.valid_in && bus.memwrite_in;
    assign ram_we   = is_store && (bus.alu_result_in < 8'hFE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        flag_d     = flag_q;
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        rdata_d    = rdata_q;
        io_out_d   = io_out_q;
        unique case (state_q)
            StIdle: begin
                if (is_load) begin
                    addr_d     = bus.alu_result_in;
                    rd_d       = bus.rd_in;
                    flag_d     = bus.alu_flag_in;
                    memtoreg_d = bus.memtoreg_in;
                    regwrite_d = bus.regwrite_in;
                    case (bus.alu_result_in)
                        8'hFE:   rdata_d = sync2_q;
                        8'hFF:   rdata_d = io_out_q;
                        default: rdata_d = ram[bus.alu_result_in];
                    endcase
                    state_d = StLoadWait;
                end
                if (is_store && (bus.alu_result_in == 8'hFF)) begin
                    io_out_d = bus.store_data_in;
                end
            end
            StLoadWait: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.alu_result_out = bus.alu_result_in;
        bus.rd_out         = bus.rd_in;
        bus.alu_flag_out   = bus.alu_flag_in;
        bus.memtoreg_out   = bus.memtoreg_in;
        bus.regwrite_out   = bus.regwrite_in && bus.valid_in;
        bus.stall_out      = 1'b0;
        if (state_q == StLoadWait) begin
            bus.alu_result_out = addr_q;
            bus.rd_out         = rd_q;
            bus.alu_flag_out   = flag_q;
            bus.memtoreg_out   = memtoreg_q;
            bus.regwrite_out   = regwrite_q;
        end else if (is_load) begin
            bus.stall_out    = 1'b1;
            bus.regwrite_out = 1'b0;
        end
        // Keep WB and upstream quiet for the whole reset pulse, not just after the next edge.
        if (!reset_n) begin
            bus.stall_out    = 1'b0;
            bus.regwrite_out = 1'b0;
        end
    end

    assign bus.mem_data_out = rdata_q;
    assign bus.io_out       = io_out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= 8'h00;
            rd_q       <= 3'h0;
            flag_q     <= 4'h0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            rdata_q    <= 8'h00;
            io_out_q   <= 8'h00;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            flag_q     <= flag_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            rdata_q    <= rdata_d;
            io_out_q   <= io_out_d;
            sync1_q    <= bus.io_in;
            sync2_q    <= sync1_q;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[bus.alu_result_in] <= bus.store_data_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written I/O and reset
// sequences, then random transactions against a byte-array memory model.
module tb_mem_stage;

    typedef struct {
        logic       v, mr, mw, rw, mtr;
        logic [7:0] addr, sd;
        logic [2:0] rd;
        logic [3:0] flg;
    } in_t;

    typedef struct {
        logic       stall, rw, mtr;
        logic [2:0] rd;
        logic [3:0] flg;
        logic [7:0] alu, md, io;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    logic [7:0] m_mem [256];
    logic [7:0] m_io, m_md, m_fe;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic in_t mk_in(logic v, logic mr, logic mw, logic rw, logic mtr,
                                  logic [7:0] addr, logic [7:0] sd, logic [2:0] rd,
                                  logic [3:0] flg);
        in_t r;
        r.v = v; r.mr = mr; r.mw = mw; r.rw = rw; r.mtr = mtr;
        r.addr = addr; r.sd = sd; r.rd = rd; r.flg = flg;
        return r;
    endfunction

    function automatic exp_t mk_exp(logic stall, logic rw, logic [2:0] rd, logic [7:0] alu,
                                    logic [3:0] flg, logic mtr, logic [7:0] md,
                                    logic [7:0] io);
        exp_t r;
        r.stall = stall; r.rw = rw; r.rd = rd; r.alu = alu;
        r.flg = flg; r.mtr = mtr; r.md = md; r.io = io;
        return r;
    endfunction

    function automatic void add(in_t i, exp_t e);
        vec_t r;
        r.i = i;
        r.e = e;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        bus.valid_in      = i.v;
        bus.memread_in    = i.mr;
        bus.memwrite_in   = i.mw;
        bus.regwrite_in   = i.rw;
        bus.memtoreg_in   = i.mtr;
        bus.alu_result_in = i.addr;
        bus.store_data_in = i.sd;
        bus.rd_in         = i.rd;
        bus.alu_flag_in   = i.flg;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, " stall"},    {7'b0, bus.stall_out},    {7'b0, e.stall});
        chk({tag, " regwrite"}, {7'b0, bus.regwrite_out}, {7'b0, e.rw});
        chk({tag, " rd"},       {5'b0, bus.rd_out},       {5'b0, e.rd});
        chk({tag, " alu"},      bus.alu_result_out,       e.alu);
        chk({tag, " flags"},    {4'b0, bus.alu_flag_out}, {4'b0, e.flg});
        chk({tag, " memtoreg"}, {7'b0, bus.memtoreg_out}, {7'b0, e.mtr});
        chk({tag, " memdata"},  bus.mem_data_out,         e.md);
        chk({tag, " io_out"},   bus.io_out,               e.io);
    endtask

    // Drive just after a posedge, check at the following negedge, return just after the next posedge.
    task automatic cycle(input string tag, input in_t i, input exp_t e);
        drive(i);
        @(negedge clk);
        check_out(tag, e);
        @(posedge clk);
        #1;
    endtask

    // One transaction through the model: pass-through / store in one cycle, load in two.
    task automatic model_op(input string tag, input in_t i);
        logic [7:0] val;
        if (i.v && i.mr && !i.mw) begin
            cycle({tag, " issue"}, i,
                  mk_exp(1'b1, 1'b0, i.rd, i.addr, i.flg, i.mtr, m_md, m_io));
            val  = (i.addr == 8'hFE) ? m_fe : (i.addr == 8'hFF) ? m_io : m_mem[i.addr];
            m_md = val;
            cycle({tag, " wait"}, i,
                  mk_exp(1'b0, i.rw, i.rd, i.addr, i.flg, i.mtr, m_md, m_io));
        end else begin
            cycle(tag, i,
                  mk_exp(1'b0, i.rw & i.v, i.rd, i.addr, i.flg, i.mtr, m_md, m_io));
            if (i.v && i.mw) begin
                if (i.addr == 8'hFF) m_io = i.sd;
                else if (i.addr < 8'hFE) m_mem[i.addr] = i.sd;
            end
        end
    endtask

    initial begin
        in_t idle;
        in_t ri;
        int  kind;
        int  pick;
        idle = mk_in(0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 4'h0);
        drive(idle);
        bus.io_in = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {7'b0, bus.stall_out}, 8'h00);
        chk("reset regwrite", {7'b0, bus.regwrite_out}, 8'h00);
        chk("reset memdata", bus.mem_data_out, 8'h00);
        chk("reset io_out", bus.io_out, 8'h00);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: ALU pass-through, store/load, 0xFF port, back-to-back loads,
        // store right after LOAD_WAIT, read+write treated as store, write to 0xFE ignored.
        add(mk_in(0, 0, 0, 1, 0, 8'h33, 8'h00, 3'd1, 4'h2), mk_exp(0, 0, 3'd1, 8'h33, 4'h2, 0, 8'h00, 8'h00));
        add(mk_in(1, 0, 0, 1, 0, 8'h44, 8'h00, 3'd2, 4'h5), mk_exp(0, 1, 3'd2, 8'h44, 4'h5, 0, 8'h00, 8'h00));
        add(mk_in(1, 0, 1, 0, 0, 8'h10, 8'h5A, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'h10, 4'h0, 0, 8'h00, 8'h00));
        add(mk_in(1, 1, 0, 1, 1, 8'h10, 8'h00, 3'd3, 4'h1), mk_exp(1, 0, 3'd3, 8'h10, 4'h1, 1, 8'h00, 8'h00));
        add(mk_in(1, 0, 0, 0, 0, 8'h99, 8'h00, 3'd6, 4'hF), mk_exp(0, 1, 3'd3, 8'h10, 4'h1, 1, 8'h5A, 8'h00));
        add(mk_in(1, 0, 1, 0, 0, 8'hFF, 8'hA5, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'hFF, 4'h0, 0, 8'h5A, 8'h00));
        add(mk_in(1, 1, 0, 1, 1, 8'hFF, 8'h00, 3'd4, 4'h0), mk_exp(1, 0, 3'd4, 8'hFF, 4'h0, 1, 8'h5A, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'hFF, 8'h00, 3'd4, 4'h0), mk_exp(0, 1, 3'd4, 8'hFF, 4'h0, 1, 8'hA5, 8'hA5));
        add(mk_in(1, 0, 1, 0, 0, 8'h01, 8'h11, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'h01, 4'h0, 0, 8'hA5, 8'hA5));
        add(mk_in(1, 0, 1, 0, 0, 8'h02, 8'h22, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'h02, 4'h0, 0, 8'hA5, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h01, 8'h00, 3'd5, 4'h0), mk_exp(1, 0, 3'd5, 8'h01, 4'h0, 1, 8'hA5, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h01, 8'h00, 3'd5, 4'h0), mk_exp(0, 1, 3'd5, 8'h01, 4'h0, 1, 8'h11, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h02, 8'h00, 3'd6, 4'h0), mk_exp(1, 0, 3'd6, 8'h02, 4'h0, 1, 8'h11, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h02, 8'h00, 3'd6, 4'h0), mk_exp(0, 1, 3'd6, 8'h02, 4'h0, 1, 8'h22, 8'hA5));
        add(mk_in(1, 1, 1, 0, 0, 8'h20, 8'h77, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'h20, 4'h0, 0, 8'h22, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h20, 8'h00, 3'd7, 4'h0), mk_exp(1, 0, 3'd7, 8'h20, 4'h0, 1, 8'h22, 8'hA5));
        add(mk_in(1, 1, 0, 1, 1, 8'h20, 8'h00, 3'd7, 4'h0), mk_exp(0, 1, 3'd7, 8'h20, 4'h0, 1, 8'h77, 8'hA5));
        add(mk_in(1, 0, 1, 0, 0, 8'hFE, 8'h11, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'hFE, 4'h0, 0, 8'h77, 8'hA5));
        add(mk_in(0, 0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 4'h0), mk_exp(0, 0, 3'd0, 8'h00, 4'h0, 0, 8'h77, 8'hA5));
        for (int k = 0; k < tbl.size(); k++) begin
            cycle($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
        end

        // Input port through the synchronizer.
        bus.io_in = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            cycle("io settle", idle, mk_exp(0, 0, 3'd0, 8'h00, 4'h0, 0, 8'h77, 8'hA5));
        end
        ri = mk_in(1, 1, 0, 1, 1, 8'hFE, 8'h00, 3'd1, 4'h0);
        cycle("io load issue", ri, mk_exp(1, 0, 3'd1, 8'hFE, 4'h0, 1, 8'h77, 8'hA5));
        cycle("io load wait", ri, mk_exp(0, 1, 3'd1, 8'hFE, 4'h0, 1, 8'h3C, 8'hA5));

        // Reset pulse in LOAD_WAIT aborts the load; RAM survives.
        ri = mk_in(1, 1, 0, 1, 1, 8'h10, 8'h00, 3'd3, 4'h0);
        cycle("rst load issue", ri, mk_exp(1, 0, 3'd3, 8'h10, 4'h0, 1, 8'h3C, 8'hA5));
        ri = mk_in(1, 0, 0, 1, 0, 8'h55, 8'h00, 3'd2, 4'h0);
        drive(ri);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst stall", {7'b0, bus.stall_out}, 8'h00);
        chk("rst regwrite", {7'b0, bus.regwrite_out}, 8'h00);
        chk("rst memdata", bus.mem_data_out, 8'h00);
        chk("rst io_out", bus.io_out, 8'h00);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("alu after rst", ri, mk_exp(0, 1, 3'd2, 8'h55, 4'h0, 0, 8'h00, 8'h00));
        ri = mk_in(1, 1, 0, 1, 1, 8'h10, 8'h00, 3'd3, 4'h0);
        cycle("ram kept issue", ri, mk_exp(1, 0, 3'd3, 8'h10, 4'h0, 1, 8'h00, 8'h00));
        cycle("ram kept wait", ri, mk_exp(0, 1, 3'd3, 8'h10, 4'h0, 1, 8'h5A, 8'h00));

        // Random transactions against the model.
        m_md = 8'h5A;
        m_io = 8'h00;
        m_fe = 8'h3C;
        for (int a = 0; a < 16; a++) begin
            model_op("prefill", mk_in(1, 0, 1, 0, 0, 8'(a), 8'($urandom), 3'd0, 4'h0));
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.io_in = 8'($urandom);
                m_fe = bus.io_in;
                model_op("io change", idle);
                model_op("io change", idle);
            end
            kind = $urandom_range(0, 4);
            pick = $urandom_range(0, 9);
            ri = mk_in(1, 0, 0, 0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                       3'($urandom), 4'($urandom));
            if (pick == 0) ri.addr = 8'hFE;
            else if (pick == 1) ri.addr = 8'hFF;
            case (kind)
                0: begin
                    ri.v = 1'b0; ri.mr = 1'($urandom); ri.mw = 1'($urandom);
                    ri.rw = 1'($urandom);
                end
                1: ri.rw = 1'($urandom);
                2: ri.mw = 1'b1;
                3: begin ri.mr = 1'b1; ri.rw = 1'($urandom); end
                default: begin ri.mr = 1'b1; ri.mw = 1'b1; end
            endcase
            model_op($sformatf("rand%0d", n), ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
